// File: rtl/bch63_pkg.sv
// Shared BCH(63,56) constants: code geometry, generator polynomial and encoder states.
package bch63_pkg;

   localparam int unsigned N     = 63;
   localparam int unsigned K     = 56;
   localparam int unsigned R     = 7;
   localparam int unsigned IDX_W = 6;

   localparam logic [R:0]   GEN_POLY = 8'hC5;
   localparam logic [R-1:0] GEN_LOW  = GEN_POLY[R-1:0];

   // idx values bounding the message and parity phases of the serial stream
   localparam logic [IDX_W-1:0] IDX_TOP      = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] IDX_MSG_LAST = IDX_W'(R);
   localparam logic [IDX_W-1:0] IDX_PAR_TOP  = IDX_W'(R - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MSG  = 2'd1,
      ST_PAR  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/bch_lfsr7.sv
// Single-step degree-7 LFSR: divides the input stream by g(x) or flushes the remainder out MSB first.
module bch_lfsr7
   import bch63_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic         mode,
   input  logic         bit_in,
   output logic [R-1:0] parity,
   output logic         msb_nxt_c
);

   logic [R-1:0] lfsr_q;
   logic [R-1:0] lfsr_d;
   logic         fb;

   // mode = 1 divides, mode = 0 shifts the remainder out with zero fill
   always_comb begin
      fb     = mode & (bit_in ^ lfsr_q[R-1]);
      lfsr_d = lfsr_q;
      if (clr) begin
         lfsr_d = '0;
      end else if (en) begin
         lfsr_d = {lfsr_q[R-2:0], 1'b0} ^ (fb ? GEN_LOW : R'(0));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= '0;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign parity    = lfsr_q;
   assign msb_nxt_c = lfsr_d[R-1];

endmodule

// File: rtl/bch63_56_encoder.sv
// Systematic BCH(63,56) encoder: serial codeword MSB first plus the assembled parallel codeword.
module bch63_56_encoder
   import bch63_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [K-1:0] msg_in,
   input  logic         msg_valid,
   output logic         msg_ready,
   output logic         code_bit,
   output logic         code_valid,
   output logic         code_first,
   output logic         code_last,
   output logic [N-1:0] code_word,
   output logic         done
);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [K-1:0]       msg_q, msg_d;
   logic [N-1:0]       asm_q, asm_d;
   logic [N-1:0]       code_word_q, code_word_d;
   logic               code_bit_q, code_bit_d;
   logic               code_valid_q, code_valid_d;
   logic               code_first_q, code_first_d;
   logic               code_last_q, code_last_d;
   logic               done_q, done_d;

   logic               lfsr_en;
   logic               lfsr_clr;
   logic               lfsr_mode;
   logic [R-1:0]       parity;
   logic               lfsr_msb_nxt;
   logic               accept;

   assign msg_ready = (state_q == ST_IDLE) & ~rst;
   assign accept    = msg_valid & msg_ready;

   bch_lfsr7 u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .en        (lfsr_en),
      .clr       (lfsr_clr),
      .mode      (lfsr_mode),
      .bit_in    (msg_q[K-1]),
      .parity    (parity),
      .msb_nxt_c (lfsr_msb_nxt)
   );

   // Output flops are loaded with the bit for the state being entered, so bit 62 follows the accept edge.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      msg_d        = msg_q;
      asm_d        = asm_q;
      code_word_d  = code_word_q;
      code_bit_d   = 1'b0;
      code_valid_d = 1'b0;
      code_first_d = 1'b0;
      code_last_d  = 1'b0;
      done_d       = 1'b0;
      lfsr_en      = 1'b0;
      lfsr_clr     = 1'b0;
      lfsr_mode    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               msg_d        = msg_in;
               idx_d        = IDX_TOP;
               lfsr_clr     = 1'b1;
               code_bit_d   = msg_in[K-1];
               code_valid_d = 1'b1;
               code_first_d = 1'b1;
               state_d      = ST_MSG;
            end
         end
         ST_MSG: begin
            lfsr_en      = 1'b1;
            lfsr_mode    = 1'b1;
            msg_d        = {msg_q[K-2:0], 1'b0};
            asm_d        = {asm_q[N-2:0], msg_q[K-1]};
            idx_d        = idx_q - IDX_W'(1);
            code_valid_d = 1'b1;
            if (idx_q == IDX_MSG_LAST) begin
               code_bit_d = lfsr_msb_nxt;
               state_d    = ST_PAR;
            end else begin
               code_bit_d = msg_q[K-2];
            end
         end
         ST_PAR: begin
            lfsr_en = 1'b1;
            // first parity cycle: the LFSR holds the complete remainder
            if (idx_q == IDX_PAR_TOP) begin
               asm_d = {asm_q[K-1:0], parity};
            end
            if (idx_q == '0) begin
               code_word_d = asm_q;
               done_d      = 1'b1;
               state_d     = ST_DONE;
            end else begin
               idx_d        = idx_q - IDX_W'(1);
               code_bit_d   = lfsr_msb_nxt;
               code_valid_d = 1'b1;
               code_last_d  = (idx_q == IDX_W'(1));
            end
         end
         ST_DONE: begin
            idx_d   = IDX_TOP;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= IDX_TOP;
         msg_q        <= '0;
         asm_q        <= '0;
         code_word_q  <= '0;
         code_bit_q   <= 1'b0;
         code_valid_q <= 1'b0;
         code_first_q <= 1'b0;
         code_last_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         msg_q        <= msg_d;
         asm_q        <= asm_d;
         code_word_q  <= code_word_d;
         code_bit_q   <= code_bit_d;
         code_valid_q <= code_valid_d;
         code_first_q <= code_first_d;
         code_last_q  <= code_last_d;
         done_q       <= done_d;
      end
   end

   assign code_bit   = code_bit_q;
   assign code_valid = code_valid_q;
   assign code_first = code_first_q;
   assign code_last  = code_last_q;
   assign code_word  = code_word_q;
   assign done       = done_q;

endmodule
